// File: rtl/multicycle_datapath_pkg.sv
// Shared constants for the multicycle datapath: instruction encodings,
// ALU control codes and the controller state type.
package multicycle_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/multicycle_datapath_alu.sv
// mc_alu: DATA_W-bit two's-complement ALU with {N,Z,C,V} flags.
// Subtraction is a + ~b + 1, so C=1 means "no borrow".
// Logic ops and slt report C=0, V=0; slt uses N^V and never traps.
module mc_alu
  import multicycle_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_ctrl_e         ctrl,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic              sub_mode;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              ovf;
  logic              carry;
  logic              v_flag;

  // Shared adder used by add, sub and slt
  always_comb begin
    sub_mode = (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
    b_eff    = sub_mode ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_mode};
    ovf      = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  end

  // Result select and flag generation
  always_comb begin
    result = sum[DATA_W-1:0];
    carry  = sum[DATA_W];
    v_flag = ovf;
    case (ctrl)
      ALU_AND: begin
        result = a & b;
        carry  = 1'b0;
        v_flag = 1'b0;
      end
      ALU_OR: begin
        result = a | b;
        carry  = 1'b0;
        v_flag = 1'b0;
      end
      ALU_SLT: begin
        result = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ ovf};
        carry  = 1'b0;
        v_flag = 1'b0;
      end
      default: ;
    endcase
    flags = {result[DATA_W-1], (result == '0), carry, v_flag};
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: register file, controller FSM and
// datapath registers; the ALU is the mc_alu sub-module.
//
// state    | meaning
// S_FETCH  | IR <= instruction at PC, PC <= PC+4
// S_DECODE | latch A, B, sign-extended imm and branch target
// S_EXEC   | ALU op; branch resolve; unsupported op sets illegal
// S_MEM    | hold rd/wr request until dmem_ready
// S_WB     | register file write-back
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_rd,
  output logic              dmem_wr,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [DATA_W-1:0] Dout,
  output logic [3:0]        flags,
  output logic              illegal
);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [0:31];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] dout_q;
  logic [3:0]        flags_q;
  logic              illegal_q;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic              unused_shamt;
  logic [DATA_W-1:0] rf_rs;
  logic [DATA_W-1:0] rf_rt;

  alu_ctrl_e         alu_ctrl;
  logic              alu_b_imm;
  logic              exec_legal;
  logic              branch_taken;
  logic              reg_we;
  logic [4:0]        wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;

  assign opcode       = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  assign rf_rs = (rs == 5'd0) ? '0 : regs[rs];
  assign rf_rt = (rt == 5'd0) ? '0 : regs[rt];

  assign alu_b = alu_b_imm ? imm_q : b_q;

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Branch decision is kept outside the FSM block so the ALU is not in a comb loop with it
  assign branch_taken = (state == S_EXEC) &&
                        (((opcode == OP_BEQ) &&  alu_flags[2]) ||
                         ((opcode == OP_BNE) && !alu_flags[2]));

  // Requests depend only on registered state, never on dmem_ready
  assign dmem_rd    = (state == S_MEM) && (opcode == OP_LW);
  assign dmem_wr    = (state == S_MEM) && (opcode == OP_SW);
  assign imem_addr  = pc;
  assign dmem_addr  = ADDR_W'(dout_q);
  assign dmem_wdata = b_q;
  assign Dout       = dout_q;
  assign flags      = flags_q;
  assign illegal    = illegal_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    alu_ctrl   = ALU_ADD;
    alu_b_imm  = 1'b0;
    exec_legal = 1'b0;
    reg_we     = 1'b0;
    wb_idx     = rt;
    wb_data    = dout_q;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_RTYPE: begin
            exec_legal = 1'b1;
            state_nxt  = S_WB;
            case (funct)
              FN_ADD:  alu_ctrl = ALU_ADD;
              FN_SUB:  alu_ctrl = ALU_SUB;
              FN_AND:  alu_ctrl = ALU_AND;
              FN_OR:   alu_ctrl = ALU_OR;
              FN_SLT:  alu_ctrl = ALU_SLT;
              default: begin
                exec_legal = 1'b0;
                state_nxt  = S_FETCH;
              end
            endcase
          end
          OP_ADDI: begin
            alu_b_imm  = 1'b1;
            exec_legal = 1'b1;
            state_nxt  = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_b_imm  = 1'b1;
            exec_legal = 1'b1;
            state_nxt  = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_ctrl   = ALU_SUB;
            exec_legal = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) state_nxt = (opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        state_nxt = S_FETCH;
        reg_we    = 1'b1;
        if (opcode == OP_RTYPE) wb_idx = rd;
        if (opcode == OP_LW)    wb_data = mdr;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      target    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      mdr       <= '0;
      dout_q    <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir <= imem_rdata;
          pc <= pc + ADDR_W'(4);
        end
        S_DECODE: begin
          a_q    <= rf_rs;
          b_q    <= rf_rt;
          imm_q  <= DATA_W'($signed(ir[15:0]));
          target <= pc + (ADDR_W'($signed(ir[15:0])) << 2);
        end
        S_EXEC: begin
          if (exec_legal) begin
            dout_q  <= alu_res;
            flags_q <= alu_flags;
            if (branch_taken) pc <= target;
          end else begin
            illegal_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (dmem_ready && (opcode == OP_LW)) mdr <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Register file; R0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_we && (wb_idx != 5'd0)) begin
      regs[wb_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench: an instruction-level reference model predicts the
// architectural state, per-cycle memory handshake and latency of each
// instruction; a directed prefix pins the model with literal values.
module tb_multicycle_datapath;

  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [5:0]  OP_R    = 6'h00;
  localparam logic [5:0]  OP_ADDI = 6'h08;
  localparam logic [5:0]  OP_LW   = 6'h23;
  localparam logic [5:0]  OP_SW   = 6'h2B;
  localparam logic [5:0]  OP_BEQ  = 6'h04;
  localparam logic [5:0]  OP_BNE  = 6'h05;
  localparam logic [5:0]  OP_BAD  = 6'h3F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, dout;
  logic        dmem_rd, dmem_wr, dmem_ready, illegal;
  logic [3:0]  flags;

  logic [31:0] i16_addr, i16_rdata, d16_addr;
  logic [15:0] d16_wdata, dout16;
  logic        d16_rd, d16_wr, illegal16;
  logic [3:0]  flags16;

  logic [31:0] imem     [1024];
  logic [31:0] dmem_arr [1024];

  logic [31:0] mreg [32];
  logic [31:0] mmem [1024];
  logic [31:0] mpc, mdout;
  logic [3:0]  mflags;
  logic        millegal;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cycles;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[11:2]];
  assign i16_rdata  = (i16_addr == 32'd0) ? 32'h2001_7FFF :
                      (i16_addr == 32'd4) ? 32'h0021_1020 : 32'h0;

  multicycle_datapath #(.DATA_W(32), .ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .Dout(dout), .flags(flags),
    .illegal(illegal));

  multicycle_datapath #(.DATA_W(16), .ADDR_W(32)) dut16 (
    .clk(clk), .reset(reset), .imem_addr(i16_addr), .imem_rdata(i16_rdata),
    .dmem_addr(d16_addr), .dmem_wdata(d16_wdata), .dmem_rd(d16_rd), .dmem_wr(d16_wr),
    .dmem_rdata(16'h0), .dmem_ready(1'b1), .Dout(dout16), .flags(flags16),
    .illegal(illegal16));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {OP_R, rs, rt, rd, 5'd0, fn};
  endfunction

  // Two's-complement add/sub evaluated with wide integer arithmetic
  function automatic void arith(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, sr, ua, ub;
    bit c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (sub) begin
      r  = a - b;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      r  = a + b;
      sr = sa + sb;
      c  = (ua + ub) > 64'sd4294967295;
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  task automatic model_reset();
    mpc = RST_PC;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mdout = 32'd0;
    mflags = 4'd0;
    millegal = 1'b0;
  endtask

  // Run one instruction: predict, drive dmem_ready with w wait cycles, check every cycle
  task automatic exec_instr(input logic [31:0] instr, input int w);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, wdst;
    logic [31:0] a, b, immx, res, npc;
    logic [3:0]  f;
    bit legal, wen, is_lw, is_sw, exp_mem;
    int lat;
    op = instr[31:26]; fn = instr[5:0];
    rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    immx = {{16{instr[15]}}, instr[15:0]};
    a = mreg[rs]; b = mreg[rt];
    npc = mpc + 32'd4;
    legal = 1; wen = 0; is_lw = 0; is_sw = 0; lat = 4; wdst = rt; res = 0; f = 0;
    case (op)
      OP_R: begin
        wen = 1; wdst = rd;
        case (fn)
          6'h20: arith(a, b, 0, res, f);
          6'h22: arith(a, b, 1, res, f);
          6'h24: begin res = a & b; f = {res[31], res == 32'd0, 2'b00}; end
          6'h25: begin res = a | b; f = {res[31], res == 32'd0, 2'b00}; end
          6'h2A: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                       f = {1'b0, res == 32'd0, 2'b00}; end
          default: legal = 0;
        endcase
      end
      OP_ADDI: begin arith(a, immx, 0, res, f); wen = 1; end
      OP_LW:   begin arith(a, immx, 0, res, f); wen = 1; is_lw = 1; lat = 5 + w; end
      OP_SW:   begin arith(a, immx, 0, res, f); is_sw = 1; lat = 4 + w; end
      OP_BEQ, OP_BNE: begin
        arith(a, b, 1, res, f);
        lat = 3;
        if ((a == b) == (op == OP_BEQ)) npc = mpc + 32'd4 + (immx << 2);
      end
      default: legal = 0;
    endcase
    if (!legal) begin lat = 3; wen = 0; is_lw = 0; is_sw = 0; end

    imem[mpc[11:2]] = instr;
    wr_cycles = 0;
    for (int c = 0; c < lat; c++) begin
      exp_mem = (is_lw || is_sw) && (c >= 3) && (c <= 3 + w);
      dmem_ready = (c >= 3 + w);
      dmem_rdata = dmem_ready ? dmem_arr[dmem_addr[11:2]] : $urandom();
      if (c == 0) begin
        check("pc", imem_addr, mpc);
        check("dout", dout, mdout);
        check("flags", flags, mflags);
        check("illegal", illegal, millegal);
      end
      check("dmem_rd", dmem_rd, exp_mem && is_lw);
      check("dmem_wr", dmem_wr, exp_mem && is_sw);
      if (dmem_wr) wr_cycles++;
      if (exp_mem) begin
        check("dmem_addr", dmem_addr, res);
        if (is_sw) check("dmem_wdata", dmem_wdata, b);
        if (dmem_wr && dmem_ready) dmem_arr[dmem_addr[11:2]] = dmem_wdata;
      end
      @(negedge clk);
    end

    if (legal) begin
      mdout = res;
      mflags = f;
      if (wen && wdst != 5'd0) mreg[wdst] = is_lw ? mmem[res[11:2]] : res;
      if (is_sw) mmem[res[11:2]] = b;
    end else begin
      millegal = 1'b1;
    end
    mpc = npc;
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn_tab [5];
    int k;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    k = $urandom_range(0, 99);
    if (k < 20 || k >= 88) return enc_r(rreg(), rreg(), rreg(), fn_tab[$urandom_range(0, 4)]);
    if (k < 40) return enc_i(OP_ADDI, rreg(), rreg(), 16'($urandom()));
    if (k < 55) return enc_i(OP_LW, rreg(), rreg(), 16'($urandom_range(0, 4095)));
    if (k < 70) return enc_i(OP_SW, rreg(), rreg(), 16'($urandom_range(0, 4095)));
    if (k < 85) return enc_i(($urandom_range(0, 1) == 0) ? OP_BEQ : OP_BNE,
                             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                             16'(int'($urandom_range(0, 16)) - 8));
    if (k == 85) return enc_i(OP_BAD, rreg(), rreg(), 16'($urandom()));
    return enc_r(rreg(), rreg(), rreg(), 6'h21);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'd0;
      dmem_arr[i] = 32'd0;
      mmem[i] = 32'd0;
    end
    model_reset();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;

    repeat (3) begin
      @(negedge clk);
      check("rst_pc", imem_addr, RST_PC);
      check("rst_dout", dout, 0);
      check("rst_flags", flags, 0);
      check("rst_illegal", illegal, 0);
      check("rst_rdwr", {dmem_rd, dmem_wr}, 0);
      check("rst_pc16", i16_addr, 0);
    end
    reset = 1'b0;

    exec_instr(enc_i(OP_ADDI, 0, 1, 16'd5), 0);
    exec_instr(enc_i(OP_ADDI, 0, 2, 16'hFFFD), 0);
    exec_instr(enc_r(1, 2, 3, 6'h20), 0);
    check("model_r3", mreg[3], 2);
    check("add_dout", dout, 2);
    check("add_flags", flags, 4'b0010);
    exec_instr(enc_i(OP_SW, 0, 1, 16'd8), 3);
    check("sw_wr_cycles", wr_cycles, 4);
    check("sw_mem", dmem_arr[2], 5);
    check("sw_addr", dmem_addr, 8);
    exec_instr(enc_i(OP_LW, 0, 4, 16'd8), 1);
    check("model_r4", mreg[4], 5);
    exec_instr(enc_r(4, 0, 5, 6'h20), 0);
    check("lw_r4_dout", dout, 5);
    exec_instr(enc_i(OP_BEQ, 0, 0, 16'hFFFF), 0);
    check("beq_pc1", imem_addr, 32'h118);
    exec_instr(enc_i(OP_BEQ, 0, 0, 16'hFFFF), 0);
    check("beq_pc2", imem_addr, 32'h118);
    exec_instr(enc_i(OP_BNE, 0, 0, 16'd5), 0);
    check("bne_pc", imem_addr, 32'h11C);
    check("bne_flags", flags, 4'b0110);
    exec_instr(enc_i(OP_BAD, 1, 2, 16'd0), 0);
    check("ill_flag", illegal, 1);
    check("ill_pc", imem_addr, 32'h120);
    exec_instr(enc_r(2, 0, 6, 6'h20), 0);
    check("ill_r2_kept", dout, 32'hFFFF_FFFD);
    check("ill_sticky", illegal, 1);

    check("w16_dout", dout16, 16'hFFFE);
    check("w16_flags", flags16, 4'b1001);

    for (int n = 0; n < 400; n++) exec_instr(rand_instr(), $urandom_range(0, 3));
    for (int i = 1; i < 32; i++) exec_instr(enc_i(OP_SW, 0, 5'(i), 16'(i * 4)), 0);

    imem[mpc[11:2]] = enc_i(OP_LW, 0, 1, 16'h10);
    dmem_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("midmem_rd", dmem_rd, 1);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_rd", dmem_rd, 0);
      check("midrst_pc", imem_addr, RST_PC);
      check("midrst_dout", dout, 0);
      check("midrst_illegal", illegal, 0);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 1; i < 32; i++) exec_instr(enc_i(OP_SW, 0, 5'(i), 16'(i * 4)), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
